// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: decodes one handshaked instruction and sequences the iterative MUL/DIV ALU.
// Optional macro CU_ILLEGAL_TRAP_EN adds the IllegalOp trap output for unused opcodes.
module multicycle_control_unit #(
  parameter int OP_L     = 3,
  parameter int P        = 0,
  parameter int MAX_WAIT = 32
) (
  input  logic            Clock_i,
  input  logic            Reset_i,
  input  logic            InstrValid_i,
  output logic            InstrReady_o,
  input  logic [OP_L-1:0] Opcode_i,
  output logic            ALUStart_o,
  input  logic            ALUDone_i,
  output logic [P:0]      ALUOpcode_o,
  output logic            UseImmediate_o,
  output logic            LoadUpperImmediate_o,
  output logic            WriteBack_o,
  output logic            UpdateFlags_o,
  output logic            Busy_o,
  output logic            Timeout_o
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic            IllegalOp_o
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_e;
  typedef enum logic [1:0] {CLS_NOP, CLS_ALU, CLS_LUI} class_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             abort_d;
  logic             accept;
  class_e           decClass;
  logic [P:0]       decAluOp;
  logic             decUseImm;

  assign accept = InstrValid_i & InstrReady_o;

  always_comb begin
    decClass  = CLS_NOP;
    decAluOp  = '0;
    decUseImm = 1'b0;
    if (Opcode_i == OP_L'(7)) begin
      decClass = CLS_ALU;
      decAluOp = (P+1)'(1);
    end else if (Opcode_i == OP_L'(0)) begin
      decClass = CLS_ALU;
    end else if (Opcode_i == OP_L'(1)) begin
      decClass  = CLS_ALU;
      decAluOp  = (P+1)'(1);
      decUseImm = 1'b1;
    end else if (Opcode_i == OP_L'(2)) begin
      decClass  = CLS_ALU;
      decUseImm = 1'b1;
    end else if (Opcode_i == OP_L'(3)) begin
      decClass = CLS_LUI;
    end
  end

  // The watchdog aborts on the edge where the counter would reach MAX_WAIT-1; ALUDone on that edge wins.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (decClass == CLS_ALU) ? ISSUE : COMMIT;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        waitCnt_d = '0;
      end
      WAIT: begin
        if (ALUDone_i) begin
          state_d = COMMIT;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
          if (waitCnt_q == WAIT_LIMIT) begin
            state_d = COMMIT;
            abort_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the cycle of that state.
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q              <= IDLE;
      waitCnt_q            <= '0;
      InstrReady_o         <= 1'b1;
      Busy_o               <= 1'b0;
      ALUStart_o           <= 1'b0;
      ALUOpcode_o          <= '0;
      UseImmediate_o       <= 1'b0;
      LoadUpperImmediate_o <= 1'b0;
      WriteBack_o          <= 1'b0;
      UpdateFlags_o        <= 1'b0;
      Timeout_o            <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      IllegalOp_o          <= 1'b0;
`endif
    end else begin
      state_q              <= state_d;
      waitCnt_q            <= waitCnt_d;
      InstrReady_o         <= (state_d == IDLE);
      Busy_o               <= (state_d != IDLE);
      ALUStart_o           <= (state_d == ISSUE);
      LoadUpperImmediate_o <= 1'b0;
      WriteBack_o          <= 1'b0;
      UpdateFlags_o        <= 1'b0;
      Timeout_o            <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      IllegalOp_o          <= 1'b0;
`endif
      if (state_q == IDLE && accept) begin
        if (decClass == CLS_ALU) begin
          ALUOpcode_o    <= decAluOp;
          UseImmediate_o <= decUseImm;
        end else begin
          ALUOpcode_o    <= '0;
          UseImmediate_o <= 1'b0;
        end
        if (decClass == CLS_LUI) begin
          WriteBack_o          <= 1'b1;
          LoadUpperImmediate_o <= 1'b1;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        if (decClass == CLS_NOP) begin
          IllegalOp_o <= 1'b1;
        end
`endif
      end
      if (state_q == WAIT && state_d == COMMIT) begin
        WriteBack_o   <= ~abort_d;
        UpdateFlags_o <= ~abort_d;
        Timeout_o     <= abort_d;
      end
      if (state_d == IDLE) begin
        ALUOpcode_o    <= '0;
        UseImmediate_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit built with MAX_WAIT=4.
module tb_multicycle_control_unit;

  logic       Clock;
  logic       Reset;
  logic       InstrValid;
  logic       InstrReady;
  logic [2:0] Opcode;
  logic       ALUStart;
  logic       ALUDone;
  logic [0:0] ALUOpcode;
  logic       UseImmediate;
  logic       LoadUpperImmediate;
  logic       WriteBack;
  logic       UpdateFlags;
  logic       Busy;
  logic       Timeout;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       IllegalOp;
`endif

  int compared = 0;
  int mismatched = 0;

  multicycle_control_unit #(.OP_L(3), .P(0), .MAX_WAIT(4)) dut (
    .Clock_i              (Clock),
    .Reset_i              (Reset),
    .InstrValid_i         (InstrValid),
    .InstrReady_o         (InstrReady),
    .Opcode_i             (Opcode),
    .ALUStart_o           (ALUStart),
    .ALUDone_i            (ALUDone),
    .ALUOpcode_o          (ALUOpcode),
    .UseImmediate_o       (UseImmediate),
    .LoadUpperImmediate_o (LoadUpperImmediate),
    .WriteBack_o          (WriteBack),
    .UpdateFlags_o        (UpdateFlags),
    .Busy_o               (Busy),
    .Timeout_o            (Timeout)
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    .IllegalOp_o          (IllegalOp)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InstrValid = 1'b0; Opcode = 3'b000; ALUDone = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    compared++; if (InstrReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready got %b want 1", InstrReady); end
    compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    compared++; if ({ALUStart, WriteBack, UpdateFlags, Timeout, LoadUpperImmediate} !== 5'b0) begin mismatched++; $display("[TB] FAIL reset_strobes got %b want 00000", {ALUStart, WriteBack, UpdateFlags, Timeout, LoadUpperImmediate}); end
    compared++; if ({ALUOpcode, UseImmediate} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_decode got %b want 00", {ALUOpcode, UseImmediate}); end
  endtask

  // MUL with ALUDone three cycles after ALUStart, which is also the watchdog limit edge.
  task automatic test_mul();
    InstrValid = 1'b1; Opcode = 3'b111;
    tick();
    InstrValid = 1'b0; Opcode = 3'b000;
    compared++; if (ALUStart !== 1'b1) begin mismatched++; $display("[TB] FAIL mul_start got %b want 1", ALUStart); end
    compared++; if ({ALUOpcode, UseImmediate} !== 2'b10) begin mismatched++; $display("[TB] FAIL mul_decode got %b want 10", {ALUOpcode, UseImmediate}); end
    compared++; if ({InstrReady, Busy} !== 2'b01) begin mismatched++; $display("[TB] FAIL mul_issue_rdy_busy got %b want 01", {InstrReady, Busy}); end
    tick();
    compared++; if ({ALUStart, ALUOpcode, InstrReady, WriteBack} !== 4'b0100) begin mismatched++; $display("[TB] FAIL mul_wait1 got %b want 0100", {ALUStart, ALUOpcode, InstrReady, WriteBack}); end
    tick();
    tick();
    ALUDone = 1'b1;
    compared++; if ({WriteBack, Timeout, InstrReady} !== 3'b000) begin mismatched++; $display("[TB] FAIL mul_wait3 got %b want 000", {WriteBack, Timeout, InstrReady}); end
    tick();
    ALUDone = 1'b0;
    compared++; if ({WriteBack, UpdateFlags, Timeout} !== 3'b110) begin mismatched++; $display("[TB] FAIL mul_commit got %b want 110", {WriteBack, UpdateFlags, Timeout}); end
    compared++; if ({ALUOpcode, InstrReady, Busy} !== 3'b101) begin mismatched++; $display("[TB] FAIL mul_commit_hold got %b want 101", {ALUOpcode, InstrReady, Busy}); end
    tick();
    compared++; if ({WriteBack, UpdateFlags, InstrReady, Busy, ALUOpcode} !== 5'b00100) begin mismatched++; $display("[TB] FAIL mul_idle got %b want 00100", {WriteBack, UpdateFlags, InstrReady, Busy, ALUOpcode}); end
  endtask

  // DIVi finishing in the first WAIT cycle, followed immediately by a back-to-back LUI.
  task automatic test_divi_back_to_back();
    InstrValid = 1'b1; Opcode = 3'b010;
    tick();
    InstrValid = 1'b0;
    compared++; if ({ALUStart, ALUOpcode, UseImmediate} !== 3'b101) begin mismatched++; $display("[TB] FAIL divi_issue got %b want 101", {ALUStart, ALUOpcode, UseImmediate}); end
    tick();
    ALUDone = 1'b1;
    tick();
    ALUDone = 1'b0;
    compared++; if ({WriteBack, UpdateFlags, UseImmediate, ALUOpcode} !== 4'b1110) begin mismatched++; $display("[TB] FAIL divi_commit got %b want 1110", {WriteBack, UpdateFlags, UseImmediate, ALUOpcode}); end
    tick();
    compared++; if ({InstrReady, WriteBack, UseImmediate} !== 3'b100) begin mismatched++; $display("[TB] FAIL divi_ready got %b want 100", {InstrReady, WriteBack, UseImmediate}); end
    InstrValid = 1'b1; Opcode = 3'b011;
    tick();
    InstrValid = 1'b0;
    compared++; if ({WriteBack, LoadUpperImmediate, UpdateFlags, ALUStart, Busy} !== 5'b11001) begin mismatched++; $display("[TB] FAIL lui_commit got %b want 11001", {WriteBack, LoadUpperImmediate, UpdateFlags, ALUStart, Busy}); end
    tick();
    compared++; if ({WriteBack, LoadUpperImmediate, ALUStart, InstrReady, Busy} !== 5'b00010) begin mismatched++; $display("[TB] FAIL lui_idle got %b want 00010", {WriteBack, LoadUpperImmediate, ALUStart, InstrReady, Busy}); end
  endtask

  task automatic test_timeout();
    InstrValid = 1'b1; Opcode = 3'b111; ALUDone = 1'b0;
    tick();
    InstrValid = 1'b0;
    tick(); tick(); tick();
    compared++; if ({Timeout, WriteBack, Busy} !== 3'b001) begin mismatched++; $display("[TB] FAIL timeout_wait3 got %b want 001", {Timeout, WriteBack, Busy}); end
    tick();
    compared++; if ({Timeout, WriteBack, UpdateFlags} !== 3'b100) begin mismatched++; $display("[TB] FAIL timeout_abort got %b want 100", {Timeout, WriteBack, UpdateFlags}); end
    tick();
    compared++; if ({Timeout, InstrReady, Busy} !== 3'b010) begin mismatched++; $display("[TB] FAIL timeout_idle got %b want 010", {Timeout, InstrReady, Busy}); end
  endtask

  task automatic test_illegal();
    InstrValid = 1'b1; Opcode = 3'b101;
    tick();
    InstrValid = 1'b0;
    compared++; if ({Busy, WriteBack, UpdateFlags, ALUStart} !== 4'b1000) begin mismatched++; $display("[TB] FAIL illegal_commit got %b want 1000", {Busy, WriteBack, UpdateFlags, ALUStart}); end
`ifdef CU_ILLEGAL_TRAP_EN
    compared++; if (IllegalOp !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_trap got %b want 1", IllegalOp); end
`endif
    tick();
    compared++; if ({Busy, InstrReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL illegal_idle got %b want 01", {Busy, InstrReady}); end
`ifdef CU_ILLEGAL_TRAP_EN
    compared++; if (IllegalOp !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_clear got %b want 0", IllegalOp); end
`endif
  endtask

  // ALUDone held through ISSUE must not skip WAIT; then reset in WAIT with a late ALUDone.
  task automatic test_reset_in_wait();
    InstrValid = 1'b1; Opcode = 3'b000; ALUDone = 1'b1;
    tick();
    InstrValid = 1'b0;
    compared++; if ({ALUStart, ALUOpcode, UseImmediate, WriteBack} !== 4'b1000) begin mismatched++; $display("[TB] FAIL div_issue got %b want 1000", {ALUStart, ALUOpcode, UseImmediate, WriteBack}); end
    ALUDone = 1'b0;
    tick();
    compared++; if ({Busy, WriteBack, ALUStart} !== 3'b100) begin mismatched++; $display("[TB] FAIL div_wait got %b want 100", {Busy, WriteBack, ALUStart}); end
    Reset = 1'b1; ALUDone = 1'b1;
    tick();
    Reset = 1'b0;
    compared++; if ({InstrReady, Busy, WriteBack, UpdateFlags} !== 4'b1000) begin mismatched++; $display("[TB] FAIL rst_wait got %b want 1000", {InstrReady, Busy, WriteBack, UpdateFlags}); end
    tick();
    ALUDone = 1'b0;
    compared++; if ({InstrReady, Busy, WriteBack, UpdateFlags, Timeout} !== 5'b10000) begin mismatched++; $display("[TB] FAIL rst_late_done got %b want 10000", {InstrReady, Busy, WriteBack, UpdateFlags, Timeout}); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divi_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
